// File: rtl/filter_event_ctrl_pkg.sv
// Shared definitions for the filter event controller: data widths, default
// sequencing lengths, the controller state type and small helper functions.
package filter_event_ctrl_pkg;

    localparam int SIZE_ADC_DATA    = 12;
    localparam int SIZE_FILTER_DATA = 15;

    localparam int CLR_LEN_DEF    = 2;
    localparam int SETTLE_LEN_DEF = 32;
    localparam int WIN_LEN_DEF    = 64;
    localparam int TS_W_DEF       = 32;

    // Shared phase counter width; must cover CLR_LEN, SETTLE_LEN and WIN_LEN.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ARMED  = 3'd2,
        ST_SEARCH = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Rising crossing of an unsigned level between two consecutive samples.
    function automatic logic rising_cross(
        input logic [SIZE_ADC_DATA-1:0] prev,
        input logic [SIZE_ADC_DATA-1:0] cur,
        input logic [SIZE_ADC_DATA-1:0] level
    );
        return (prev < level) && (cur >= level);
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/filter_event_ctrl_if.sv
// Event record handshake between the controller (master) and its consumer.
interface filter_event_ctrl_if
    import filter_event_ctrl_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
);

    logic                          event_valid;
    logic                          event_ready;
    logic signed [SIZE_FILTER_DATA:0] event_amp;
    logic [TS_W-1:0]               event_ts;
    logic [7:0]                    event_ofs;
    logic                          event_pileup;

    modport master (
        output event_valid,
        output event_amp,
        output event_ts,
        output event_ofs,
        output event_pileup,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_amp,
        input  event_ts,
        input  event_ofs,
        input  event_pileup,
        output event_ready
    );

endinterface

// File: rtl/filter_event_ctrl_peak_tracker.sv
// Running signed maximum of the filter output over a search window. The first
// window sample is loaded unconditionally; later samples replace the maximum
// only when strictly larger, so the earliest of equal peaks is kept.
module peak_tracker
    import filter_event_ctrl_pkg::*;
#(
    parameter int DW = SIZE_FILTER_DATA + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 update,
    input  logic signed [DW-1:0] din,
    input  logic [7:0]           idx,
    output logic signed [DW-1:0] max,
    output logic [7:0]           ofs
);

    // Maximum value and the window index where it was first seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            max <= '0;
            ofs <= 8'd0;
        end else if (load) begin
            max <= din;
            ofs <= 8'd0;
        end else if (update && (din > max)) begin
            max <= din;
            ofs <= idx;
        end else begin
            max <= max;
            ofs <= ofs;
        end
    end

endmodule

// File: rtl/filter_event_ctrl.sv
// Event controller for a pulse-processing filter: clears and settles the
// filter, arms on a rising threshold crossing of the raw ADC stream, searches
// a fixed window for the filter peak and presents one record per event.
module filter_event_ctrl
    import filter_event_ctrl_pkg::*;
#(
    parameter int CLR_LEN    = CLR_LEN_DEF,
    parameter int SETTLE_LEN = SETTLE_LEN_DEF,
    parameter int WIN_LEN    = WIN_LEN_DEF,
    parameter int TS_W       = TS_W_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [SIZE_ADC_DATA-1:0]         threshold,
    input  logic [SIZE_ADC_DATA-1:0]         adc_data,
    input  logic signed [SIZE_FILTER_DATA:0] filt_data,
    output logic                             filt_rst_n,
    filter_event_ctrl_if.master              ev,
    output logic [15:0]                      lost_cnt,
    output logic                             busy
);

    state_t                       state;
    state_t                       state_next;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             cnt_next;
    logic [SIZE_ADC_DATA-1:0]     adc_prev;
    logic [SIZE_ADC_DATA-1:0]     thr_lat;
    logic [SIZE_ADC_DATA-1:0]     thr_eff;
    logic                         trig;
    logic                         start_event;
    logic                         trk_load;
    logic                         trk_update;
    logic [TS_W-1:0]              ts_cnt;
    logic [TS_W-1:0]              ts_latch;
    logic                         pileup;
    logic                         valid;
    logic signed [SIZE_FILTER_DATA:0] peak_max;
    logic [7:0]                   peak_ofs;

    // Trigger detect: during an event the level captured at arming applies,
    // otherwise the live threshold input is used.
    always_comb begin
        thr_eff = threshold;
        if ((state == ST_SEARCH) || (state == ST_HOLD)) begin
            thr_eff = thr_lat;
        end else begin
            thr_eff = threshold;
        end
        trig = rising_cross(adc_prev, adc_data, thr_eff);
    end

    // Next-state, phase counter and peak tracker control.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CNT_W'(1);
        start_event = 1'b0;
        trk_load    = 1'b0;
        trk_update  = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (cnt == CNT_W'(CLR_LEN - 1)) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_CLEAR;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_W'(SETTLE_LEN - 1)) begin
                    state_next = ST_ARMED;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_ARMED: begin
                cnt_next = '0;
                if (trig && en) begin
                    start_event = 1'b1;
                    state_next  = ST_SEARCH;
                end else begin
                    state_next  = ST_ARMED;
                end
            end
            ST_SEARCH: begin
                if (cnt == '0) begin
                    trk_load = 1'b1;
                end else begin
                    trk_update = 1'b1;
                end
                if (cnt == CNT_W'(WIN_LEN - 1)) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_SEARCH;
                end
            end
            ST_HOLD: begin
                cnt_next = '0;
                if (ev.event_ready) begin
                    state_next = ST_CLEAR;
                end else begin
                    state_next = ST_HOLD;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // State and phase counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Previous ADC sample for edge detection and free-running timestamp.
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_prev <= '0;
            ts_cnt   <= '0;
        end else begin
            adc_prev <= adc_data;
            ts_cnt   <= ts_cnt + TS_W'(1);
        end
    end

    // Per-event capture: threshold and timestamp at arming, pileup in window.
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_lat  <= '0;
            ts_latch <= '0;
            pileup   <= 1'b0;
        end else if (start_event) begin
            thr_lat  <= threshold;
            ts_latch <= ts_cnt;
            pileup   <= 1'b0;
        end else if ((state == ST_SEARCH) && trig) begin
            pileup   <= 1'b1;
        end else begin
            pileup   <= pileup;
        end
    end

    // Saturating count of triggers arriving while not able to start an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            lost_cnt <= 16'd0;
        end else if (trig && ((state == ST_CLEAR) || (state == ST_SETTLE) || (state == ST_HOLD))) begin
            lost_cnt <= sat_inc16(lost_cnt);
        end else begin
            lost_cnt <= lost_cnt;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_rst_n <= 1'b0;
            busy       <= 1'b1;
            valid      <= 1'b0;
        end else begin
            filt_rst_n <= (state_next != ST_CLEAR);
            busy       <= (state_next != ST_ARMED);
            valid      <= (state_next == ST_HOLD);
        end
    end

    peak_tracker #(
        .DW(SIZE_FILTER_DATA + 1)
    ) u_peak (
        .clk    (clk),
        .reset  (reset),
        .load   (trk_load),
        .update (trk_update),
        .din    (filt_data),
        .idx    (cnt[7:0]),
        .max    (peak_max),
        .ofs    (peak_ofs)
    );

    assign ev.event_valid  = valid;
    assign ev.event_amp    = peak_max;
    assign ev.event_ts     = ts_latch;
    assign ev.event_ofs    = peak_ofs;
    assign ev.event_pileup = pileup;

endmodule

// File: tb/tb_filter_event_ctrl.sv
// Bench for filter_event_ctrl: directed scenarios plus a randomized run, all
// checked against an interval-based model of the event sequence.
module tb_filter_event_ctrl;
    import filter_event_ctrl_pkg::*;

    localparam int CLR  = 2;
    localparam int SET  = 32;
    localparam int WIN  = 64;
    localparam int TSW  = 32;
    localparam int MAXN = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                             reset;
    logic                             en;
    logic [SIZE_ADC_DATA-1:0]         threshold;
    logic [SIZE_ADC_DATA-1:0]         adc_data;
    logic signed [SIZE_FILTER_DATA:0] filt_data;
    logic                             filt_rst_n;
    logic [15:0]                      lost_cnt;
    logic                             busy;

    filter_event_ctrl_if #(.TS_W(TSW)) ev ();

    filter_event_ctrl #(
        .CLR_LEN(CLR), .SETTLE_LEN(SET), .WIN_LEN(WIN), .TS_W(TSW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .threshold(threshold),
        .adc_data(adc_data), .filt_data(filt_data), .filt_rst_n(filt_rst_n),
        .ev(ev), .lost_cnt(lost_cnt), .busy(busy)
    );

    typedef struct {
        int                           cyc;
        logic signed [SIZE_FILTER_DATA:0] amp;
        logic [TSW-1:0]               ts;
        logic [7:0]                   ofs;
        logic                         pile;
    } rec_t;

    logic [SIZE_ADC_DATA-1:0]         adc_a [MAXN];
    logic [SIZE_ADC_DATA-1:0]         thr_a [MAXN];
    logic signed [SIZE_FILTER_DATA:0] filt_a[MAXN];
    bit en_a[MAXN], rdy_a[MAXN];
    bit o_rstn[MAXN], o_busy[MAXN], o_valid[MAXN];
    bit e_rstn[MAXN], e_busy[MAXN], e_valid[MAXN];
    rec_t obs_q[$];
    rec_t exp_q[$];
    int   exp_lost;
    logic [15:0] obs_lost;
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic bit trig_at(input int i, input logic [SIZE_ADC_DATA-1:0] lvl);
        logic [SIZE_ADC_DATA-1:0] prev;
        prev = (i == 0) ? '0 : adc_a[i-1];
        return (prev < lvl) && (adc_a[i] >= lvl);
    endfunction

    task automatic fill_idle();
        for (int i = 0; i < MAXN; i++) begin
            adc_a[i] = '0; thr_a[i] = 12'd100; filt_a[i] = '0;
            en_a[i] = 1'b1; rdy_a[i] = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rstn"},   64'(filt_rst_n), 64'd0);
        check({tag, "_busy"},   64'(busy), 64'd1);
        check({tag, "_valid"},  64'(ev.event_valid), 64'd0);
        check({tag, "_amp"},    64'(ev.event_amp), 64'd0);
        check({tag, "_ts"},     64'(ev.event_ts), 64'd0);
        check({tag, "_ofs"},    64'(ev.event_ofs), 64'd0);
        check({tag, "_pileup"}, 64'(ev.event_pileup), 64'd0);
        check({tag, "_lost"},   64'(lost_cnt), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; adc_data = '0; en = 1'b0; filt_data = '0;
        threshold = 12'd100; ev.event_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals(tag);
    endtask

    // Plays cycles 0..n-1 of the stimulus arrays, recording outputs per cycle.
    task automatic run(input int n, input string tag);
        rec_t held;
        rec_t r;
        obs_q.delete();
        held = '{0, '0, '0, '0, 1'b0};
        for (int i = 0; i < n; i++) begin
            o_rstn[i]  = filt_rst_n;
            o_busy[i]  = busy;
            o_valid[i] = ev.event_valid;
            if (i > 0 && o_valid[i-1] && !rdy_a[i-1]) begin
                check({tag, "_hold_valid"}, 64'(ev.event_valid), 64'd1);
                check({tag, "_hold_amp"},   64'(ev.event_amp), 64'(held.amp));
                check({tag, "_hold_ts"},    64'(ev.event_ts), 64'(held.ts));
                check({tag, "_hold_ofs"},   64'(ev.event_ofs), 64'(held.ofs));
                check({tag, "_hold_pile"},  64'(ev.event_pileup), 64'(held.pile));
            end
            held.amp = ev.event_amp; held.ts = ev.event_ts;
            held.ofs = ev.event_ofs; held.pile = ev.event_pileup;
            if (ev.event_valid && rdy_a[i]) begin
                r = held; r.cyc = i;
                obs_q.push_back(r);
            end
            reset = 1'b0; adc_data = adc_a[i]; threshold = thr_a[i];
            filt_data = filt_a[i]; en = en_a[i]; ev.event_ready = rdy_a[i];
            @(negedge clk);
        end
        obs_lost = lost_cnt;
    endtask

    // Walks the timeline as intervals: clear+settle, armed until an enabled
    // crossing, a fixed window, then hold until the consumer accepts.
    task automatic model(input int n);
        int c, t, h;
        logic [SIZE_ADC_DATA-1:0] lt;
        rec_t r;
        exp_q.delete();
        exp_lost = 0;
        for (int i = 0; i < n; i++) begin
            e_rstn[i] = 1'b1; e_busy[i] = 1'b1; e_valid[i] = 1'b0;
        end
        c = 0;
        while (c < n) begin
            for (int i = c; i < c + CLR + SET && i < n; i++) begin
                if (i < c + CLR) e_rstn[i] = 1'b0;
                if (trig_at(i, thr_a[i])) exp_lost++;
            end
            t = c + CLR + SET;
            while (t < n && !(en_a[t] && trig_at(t, thr_a[t]))) begin
                e_busy[t] = 1'b0;
                t++;
            end
            if (t >= n) break;
            e_busy[t] = 1'b0;
            lt = thr_a[t];
            r.amp = filt_a[t+1]; r.ofs = 8'd0; r.pile = 1'b0; r.ts = TSW'(t);
            for (int k = 0; k < WIN; k++) begin
                if (filt_a[t+1+k] > r.amp) begin
                    r.amp = filt_a[t+1+k]; r.ofs = 8'(k);
                end
                if (trig_at(t + 1 + k, lt)) r.pile = 1'b1;
            end
            h = t + WIN + 1;
            while (h < n && !rdy_a[h]) begin
                e_valid[h] = 1'b1;
                if (trig_at(h, lt)) exp_lost++;
                h++;
            end
            if (h >= n) break;
            e_valid[h] = 1'b1;
            if (trig_at(h, lt)) exp_lost++;
            r.cyc = h;
            exp_q.push_back(r);
            c = h + 1;
        end
    endtask

    task automatic compare(input int n, input string tag);
        int m, bad_rstn, bad_busy, bad_valid;
        model(n);
        check({tag, "_n_events"}, 64'(obs_q.size()), 64'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_ev_cycle"}, 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
            check({tag, "_ev_amp"},   64'(obs_q[i].amp), 64'(exp_q[i].amp));
            check({tag, "_ev_ts"},    64'(obs_q[i].ts),  64'(exp_q[i].ts));
            check({tag, "_ev_ofs"},   64'(obs_q[i].ofs), 64'(exp_q[i].ofs));
            check({tag, "_ev_pile"},  64'(obs_q[i].pile), 64'(exp_q[i].pile));
        end
        bad_rstn = 0; bad_busy = 0; bad_valid = 0;
        for (int i = 0; i < n; i++) begin
            if (o_rstn[i] != e_rstn[i]) bad_rstn++;
            if (o_busy[i] != e_busy[i]) bad_busy++;
            if (o_valid[i] != e_valid[i]) bad_valid++;
        end
        check({tag, "_rstn_profile_errs"},  64'(bad_rstn), 64'd0);
        check({tag, "_busy_profile_errs"},  64'(bad_busy), 64'd0);
        check({tag, "_valid_profile_errs"}, 64'(bad_valid), 64'd0);
        check({tag, "_lost"}, 64'(obs_lost), 64'(exp_lost));
    endtask

    initial begin
        int v;
        logic [SIZE_ADC_DATA-1:0] thr;
        reset = 1'b1; en = 1'b0; threshold = '0; adc_data = '0;
        filt_data = '0; ev.event_ready = 1'b0;

        // Scenario 1: single pulse, ramped filter, delayed acceptance,
        // threshold raised mid-window (must not retrigger).
        fill_idle();
        for (int i = 40; i < MAXN; i++) adc_a[i] = 12'd200;
        for (int k = 0; k < WIN; k++) filt_a[41+k] = 16'((k <= 50) ? k : 100 - k);
        for (int i = 60; i < MAXN; i++) thr_a[i] = 12'd150;
        adc_a[61] = 12'd120;
        for (int i = 125; i < MAXN; i++) rdy_a[i] = 1'b1;
        do_reset("s1_reset");
        run(170, "s1");
        compare(170, "s1");
        check("s1_rstn_c1", 64'(o_rstn[1]), 64'd0);
        check("s1_rstn_c2", 64'(o_rstn[2]), 64'd1);
        check("s1_busy_c33", 64'(o_busy[33]), 64'd1);
        check("s1_busy_c34", 64'(o_busy[34]), 64'd0);
        check("s1_count", 64'(obs_q.size()), 64'd1);
        check("s1_amp", 64'(obs_q[0].amp), 64'd50);
        check("s1_ofs", 64'(obs_q[0].ofs), 64'd50);
        check("s1_ts", 64'(obs_q[0].ts), 64'd40);
        check("s1_pile", 64'(obs_q[0].pile), 64'd0);
        check("s1_valid_c104", 64'(o_valid[104]), 64'd0);
        check("s1_valid_c105", 64'(o_valid[105]), 64'd1);
        check("s1_xfer_cycle", 64'(obs_q[0].cyc), 64'd125);
        check("s1_rstn_c126", 64'(o_rstn[126]), 64'd0);
        check("s1_rstn_c127", 64'(o_rstn[127]), 64'd0);
        check("s1_rstn_c128", 64'(o_rstn[128]), 64'd1);

        // Scenario 2: pileup, lost triggers in hold and settle, en=0 trigger.
        fill_idle();
        for (int i = 40; i < 45; i++)   adc_a[i] = 12'd200;
        for (int i = 50; i < 106; i++)  adc_a[i] = 12'd200;
        for (int i = 107; i < 118; i++) adc_a[i] = 12'd200;
        for (int i = 120; i < 152; i++) adc_a[i] = 12'd200;
        for (int i = 155; i < MAXN; i++) adc_a[i] = 12'd200;
        for (int i = 150; i <= 170; i++) en_a[i] = 1'b0;
        for (int i = 110; i < MAXN; i++) rdy_a[i] = 1'b1;
        do_reset("s2_reset");
        run(180, "s2");
        compare(180, "s2");
        check("s2_count", 64'(obs_q.size()), 64'd1);
        check("s2_pile", 64'(obs_q[0].pile), 64'd1);
        check("s2_lost", 64'(obs_lost), 64'd2);

        // Scenario 3: reset pulsed at window cycle 30.
        fill_idle();
        for (int i = 40; i < MAXN; i++) begin
            adc_a[i] = 12'd200; filt_a[i] = 16'(i % 37);
        end
        do_reset("s3_reset");
        run(71, "s3");
        compare(71, "s3");
        check("s3_in_search_busy", 64'(busy), 64'd1);
        reset = 1'b1; adc_data = '0;
        @(negedge clk);
        check_reset_vals("s3_after_pulse");

        // Scenario 4: randomized stimulus.
        fill_idle();
        thr = 12'd100;
        for (int i = 0; i < 1400; i++) begin
            if ($urandom_range(0, 49) == 0) thr = 12'($urandom_range(60, 150));
            thr_a[i] = thr;
            v = int'($urandom_range(0, 29));
            if (v == 0)      adc_a[i] = 12'($urandom_range(150, 4095));
            else if (v == 1) adc_a[i] = thr;
            else if (v == 2) adc_a[i] = thr - 12'd1;
            else             adc_a[i] = 12'($urandom_range(0, 59));
            v = int'($urandom_range(0, 40)) - 20;
            filt_a[i] = 16'(v);
            en_a[i]  = ($urandom_range(0, 4) != 0);
            rdy_a[i] = ($urandom_range(0, 3) == 0);
        end
        do_reset("s4_reset");
        run(1400, "s4");
        compare(1400, "s4");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/filter_event_ctrl.md
FILTER_EVENT_CTRL -- requirements
Module: filter_event_ctrl

Interface
REQ-001 Parameter: CLR_LEN, 2, cycles the filter is held in reset per clear.
REQ-002 Parameter: SETTLE_LEN, 32, cycles after clear before triggers are accepted.
REQ-003 Parameter: WIN_LEN, 64, peak-search window length in cycles (1..255).
REQ-004 Parameter: TS_W, 32, timestamp width.
REQ-005 Port: clk  in  1  single clock; all logic on rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: en  in  1  arm enable; triggers accepted only when high.
REQ-008 Port: threshold  in  SIZE_ADC_DATA  unsigned trigger level on raw ADC.
REQ-009 Port: adc_data  in  SIZE_ADC_DATA  raw ADC sample, same stream feeding the filter.
REQ-010 Port: filt_data  in  SIZE_FILTER_DATA+1  signed cusp-like filter output.
REQ-011 Port: filt_rst_n  out  1  active-low reset to the filter datapath.
REQ-012 Port: event_valid  out  1  event record available.
REQ-013 Port: event_ready  in  1  downstream accepts record.
REQ-014 Port: event_amp  out  SIZE_FILTER_DATA+1  peak filter value (signed).
REQ-015 Port: event_ts  out  TS_W  timestamp at trigger.
REQ-016 Port: event_ofs  out  8  cycles from trigger to peak.
REQ-017 Port: event_pileup  out  1  second trigger seen inside window.
REQ-018 Port: lost_cnt  out  16  triggers missed while not ARMED.
REQ-019 Port: busy  out  1  high in every state except ARMED.

Function
REQ-020 States: CLEAR, SETTLE, ARMED, SEARCH, HOLD; encoding free.
REQ-021 Trigger = rising crossing: previous adc_data < threshold and current adc_data >= threshold, unsigned compare.
REQ-022 CLEAR: filt_rst_n=0 for exactly CLR_LEN cycles, then SETTLE.
REQ-023 SETTLE: filt_rst_n=1, count SETTLE_LEN cycles, then ARMED.
REQ-024 ARMED: on trigger with en=1, latch timestamp counter into event_ts, go SEARCH next cycle; en=0 ignores triggers without counting them lost.
REQ-025 SEARCH: first window cycle loads max with filt_data and ofs=0; later cycles update only if filt_data > max (signed, strict), so the earliest equal peak wins.
REQ-026 SEARCH lasts exactly WIN_LEN cycles, then HOLD with event_valid=1 on the following cycle.
REQ-027 Trigger during SEARCH sets event_pileup; window is not restarted.
REQ-028 HOLD: event_* stable while event_valid=1 and event_ready=0; transfer on valid&&ready, then CLEAR next cycle; event_ready ignored outside HOLD.
REQ-029 Trigger in CLEAR, SETTLE or HOLD increments lost_cnt, saturating at 16'hFFFF.
REQ-030 Timestamp counter: TS_W-bit free-running, +1 per cycle, wraps to 0, cleared only by reset.
REQ-031 en deasserted in SEARCH or HOLD does not abort the event; sequence completes.
REQ-032 threshold latched at ARMED->SEARCH transition; changes during an event have no effect until next ARMED.

Reset
REQ-033 reset=1 forces state CLEAR with CLEAR count restarted, filt_rst_n=0, event_valid=0, event_amp=0, event_ts=0, event_ofs=0, event_pileup=0, lost_cnt=0, timestamp=0, busy=1.
REQ-034 reset asserted mid-SEARCH or mid-HOLD discards the pending event; no partial handshake.

Structure
REQ-035 State typedef and CLR/SETTLE/WIN defaults shall live in the shared package beside SIZE_ADC_DATA and SIZE_FILTER_DATA.
REQ-036 Peak max/offset tracking shall be a sub-module named peak_tracker (load, update, max, ofs).

Verification
REQ-037 Reset release, en=1, adc=0 -> filt_rst_n low 2 cycles, busy high 34 cycles, then ARMED.
REQ-038 threshold=100, adc step 0->200, filt_data ramp 0..50 then down -> event_amp=50, event_ofs=50, event_valid 65 cycles after trigger.
REQ-039 event_ready held 0 for 20 cycles in HOLD -> outputs stable, single transfer, then filt_rst_n low 2 cycles.
REQ-040 Two crossings 10 cycles apart -> event_pileup=1, one event only.
REQ-041 Crossings during HOLD and SETTLE -> lost_cnt=2; en=0 crossing in ARMED -> lost_cnt unchanged.
REQ-042 reset pulsed at window cycle 30 -> no event_valid, all outputs at reset values.
